cdc_toggle_arbiter: RTL and testbench

- Destination-domain controller for a bank of toggle-based CDC channels.
- Each requester crosses its request toggle through a 2-stage synchronizer register. This block consumes the synchronized toggles and detects new requests.
- It grants requests one at a time to a single downstream consumer through a round-robin valid/ready handshake.
- It returns a per-channel acknowledge toggle, which crosses back to the source through another synchronizer.

---
 rtl/cdc_toggle_arbiter.sv | 153 +++++++++++++++
 tb/tb_cdc_toggle_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_toggle_arbiter.sv
// cdc_toggle_arbiter
//   Destination-domain controller for a bank of toggle-based CDC channels.
//   Consumes already-synchronized request toggles, flags each level change as
//   a request, and grants outstanding requests one at a time to a single
//   consumer through a round-robin valid/ready handshake. Each accepted grant
//   flips that channel's acknowledge toggle, which is returned to the source.
//
// Ports
//   i_clk          single clock for all logic
//   i_rst          asynchronous reset, active-high
//   i_req_tgl      synchronized request toggles, one bit per channel
//   o_ack_tgl      acknowledge toggles, bit k flips once per accepted grant of k
//   o_valid        a grant is offered to the consumer
//   o_idx          channel index of the offered grant
//   i_ready        consumer accepts the offered grant
//   o_pending      per-channel outstanding-request flags
//   o_overrun      sticky: a channel toggled again while already pending
//   i_clr_overrun  clears o_overrun on the next edge (a new overrun wins)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no offer out; pick a round-robin winner from o_pending
// S_OFFER | o_valid/o_idx held stable until the consumer accepts

module cdc_toggle_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req_tgl,
  output logic [N_REQ-1:0] o_ack_tgl,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  input  logic             i_ready,
  output logic [N_REQ-1:0] o_pending,
  output logic             o_overrun,
  input  logic             i_clr_overrun
);

  typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] last_q;
  logic [N_REQ-1:0] chg;
  logic [N_REQ-1:0] accepted;
  logic [N_REQ-1:0] merge_v;
  logic [N_REQ-1:0] pending_d;
  logic [N_REQ-1:0] ack_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W-1:0] winner;
  logic             valid_d;
  logic             overrun_d;
  logic             any_pending;

  assign chg         = i_req_tgl ^ last_q;
  assign any_pending = |o_pending;
  assign accepted    = (o_valid && i_ready && state_q == S_OFFER)
                       ? ({{(N_REQ-1){1'b0}}, 1'b1} << o_idx) : '0;

  // Round-robin search starting at ptr_q. The sum is one bit wider than the
  // index so the wrap compare is exact for non-power-of-2 channel counts.
  always_comb begin : rr_search
    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    found  = 1'b0;
    winner = ptr_q;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && o_pending[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A toggle on a channel that is pending and not being accepted this cycle
  // merges into the existing request and flags an overrun. A toggle coinciding
  // with the accept is a fresh request.
  always_comb begin : pending_update
    merge_v   = chg & o_pending & ~accepted;
    pending_d = o_pending;
    for (int k = 0; k < N_REQ; k++) begin
      if (chg[k]) begin
        pending_d[k] = 1'b1;
      end else if (accepted[k]) begin
        pending_d[k] = 1'b0;
      end
    end
    overrun_d = (|merge_v) | (o_overrun & ~i_clr_overrun);
  end

  always_comb begin : fsm_next
    state_d = state_q;
    valid_d = o_valid;
    idx_d   = o_idx;
    ptr_d   = ptr_q;
    ack_d   = o_ack_tgl;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (any_pending) begin
          valid_d = 1'b1;
          idx_d   = winner;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (i_ready) begin
          ack_d   = o_ack_tgl ^ accepted;
          ptr_d   = (o_idx == IDX_W'(N_REQ-1)) ? '0 : o_idx + 1'b1;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      last_q    <= '0;
      o_ack_tgl <= '0;
      o_pending <= '0;
      o_valid   <= 1'b0;
      o_idx     <= '0;
      o_overrun <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= i_req_tgl;
      o_ack_tgl <= ack_d;
      o_pending <= pending_d;
      o_valid   <= valid_d;
      o_idx     <= idx_d;
      o_overrun <= overrun_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_cdc_toggle_arbiter.sv
module tb_cdc_toggle_arbiter;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [N-1:0]  i_req_tgl;
  logic [N-1:0]  o_ack_tgl;
  logic          o_valid;
  logic [IW-1:0] o_idx;
  logic          i_ready;
  logic [N-1:0]  o_pending;
  logic          o_overrun;
  logic          i_clr_overrun;

  cdc_toggle_arbiter #(.N_REQ(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_tgl(i_req_tgl), .o_ack_tgl(o_ack_tgl),
    .o_valid(o_valid), .o_idx(o_idx), .i_ready(i_ready), .o_pending(o_pending),
    .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the request set, the current offer and the grant history.
  bit [N-1:0] m_last, m_pend, m_ack;
  bit         m_valid, m_ovr;
  int         m_idx, m_ptr;
  int         dut_log[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = '0; m_pend = '0; m_ack = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_idx = 0; m_ptr = 0;
    dut_log.delete();
  endtask

  task automatic compare_all();
    check("valid", 32'(o_valid), 32'(m_valid));
    if (m_valid) check("idx", 32'(o_idx), 32'(m_idx));
    check("pending", 32'(o_pending), 32'(m_pend));
    check("ack", 32'(o_ack_tgl), 32'(m_ack));
    check("overrun", 32'(o_overrun), 32'(m_ovr));
  endtask

  // One clock: inputs are already driven; advance model per rules, compare.
  task automatic step();
    bit [N-1:0] chg, acc, np;
    bit ev;
    if (o_valid && i_ready) dut_log.push_back(int'(o_idx));
    @(posedge i_clk);
    chg = i_req_tgl ^ m_last;
    acc = '0;
    if (m_valid && i_ready) acc[m_idx] = 1'b1;
    ev = 1'b0;
    np = m_pend;
    for (int k = 0; k < N; k++) begin
      if (chg[k] && m_pend[k] && !acc[k]) begin np[k] = 1'b1; ev = 1'b1; end
      else if (chg[k]) np[k] = 1'b1;
      else if (acc[k]) np[k] = 1'b0;
    end
    if (!m_valid) begin
      for (int i = 0; i < N; i++) begin
        if (!m_valid && m_pend[(m_ptr + i) % N]) begin
          m_valid = 1'b1;
          m_idx   = (m_ptr + i) % N;
        end
      end
    end else if (i_ready) begin
      m_ack[m_idx] = ~m_ack[m_idx];
      m_ptr   = (m_idx + 1) % N;
      m_valid = 1'b0;
    end
    m_pend = np;
    m_ovr  = ev | (m_ovr & ~i_clr_overrun);
    m_last = i_req_tgl;
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req_tgl = '0; i_ready = 1'b0; i_clr_overrun = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_len"}, 32'(dut_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
      check(name, 32'(dut_log[i]), 32'(exp[i]));
    dut_log.delete();
  endtask

  initial begin
    i_rst = 1'b1; i_req_tgl = '0; i_ready = 1'b0; i_clr_overrun = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_idx", 32'(o_idx), 32'd0);
    check("rst_pending", 32'(o_pending), 32'd0);
    check("rst_ack", 32'(o_ack_tgl), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    do_reset();

    // Single request on channel 2
    i_ready = 1'b1;
    i_req_tgl[2] = 1'b1;
    step();
    check("single_pend", 32'(o_pending), 32'b0100);
    check("single_v0", 32'(o_valid), 32'd0);
    step();
    check("single_v1", 32'(o_valid), 32'd1);
    check("single_idx", 32'(o_idx), 32'd2);
    step();
    check("single_ack", 32'(o_ack_tgl), 32'b0100);
    check("single_clr", 32'(o_pending), 32'd0);
    dut_log.delete();

    // Round-robin over all channels from a fresh pointer
    do_reset();
    i_ready = 1'b1;
    i_req_tgl = '1;
    steps(10);
    check_log("rr_order", '{0, 1, 2, 3});
    check("rr_ack", 32'(o_ack_tgl), 32'hF);

    // Backpressure with a competing request
    do_reset();
    i_req_tgl[1] = 1'b1;
    steps(2);
    i_req_tgl[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_idx", 32'(o_idx), 32'd1);
    end
    check("bp_pend", 32'(o_pending), 32'b1010);
    i_ready = 1'b1;
    steps(6);
    check_log("bp_order", '{1, 3});

    // Overrun: channel 0 toggles twice while pending
    do_reset();
    i_req_tgl[0] = 1'b1;
    step();
    i_req_tgl[0] = 1'b0;
    step();
    check("ovr_set", 32'(o_overrun), 32'd1);
    i_ready = 1'b1;
    steps(5);
    check_log("ovr_grants", '{0});
    i_clr_overrun = 1'b1;
    step();
    i_clr_overrun = 1'b0;
    check("ovr_clr", 32'(o_overrun), 32'd0);

    // Accept and re-toggle on the same channel in the same cycle
    do_reset();
    i_req_tgl[2] = 1'b1;
    steps(2);
    i_ready = 1'b1;
    i_req_tgl[2] = 1'b0;
    step();
    check("sim_pend", 32'(o_pending[2]), 32'd1);
    check("sim_ovr", 32'(o_overrun), 32'd0);
    check("sim_ack", 32'(o_ack_tgl[2]), 32'd1);
    steps(3);
    check_log("sim_grants", '{2, 2});

    // Reset while an offer is outstanding
    do_reset();
    i_ready = 1'b1;
    i_req_tgl[0] = 1'b1;
    steps(3);
    i_ready = 1'b0;
    i_req_tgl[1] = 1'b1;
    steps(2);
    check("mid_valid_pre", 32'(o_valid), 32'd1);
    check("mid_ack_pre", 32'(o_ack_tgl), 32'b0001);
    i_rst = 1'b1;
    #1;
    check("mid_valid", 32'(o_valid), 32'd0);
    check("mid_pend", 32'(o_pending), 32'd0);
    check("mid_ack", 32'(o_ack_tgl), 32'd0);
    i_req_tgl = '0;
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_ready = 1'b1;
    steps(6);
    check_log("mid_nogrant", '{});

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 5) == 0) i_req_tgl[k] = ~i_req_tgl[k];
      i_ready = 1'($urandom_range(0, 1));
      i_clr_overrun = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
